// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer for the MIPS-subset datapath (FETCH..WB, memory wait/timeout).
// Define ZERO_EXT_EN to decode ANDI/ORI as zero-extended logic-immediate instructions.
module mc_ctrl_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       ext_zero,
  output logic       illegal,
  output logic       mem_err,
  output logic [3:0] state_out
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             mem_state, timeout, logic_imm;
  logic             unused;

  // zero is gated with pc_write_cond inside the datapath, not in the sequencer
  assign unused = zero;

`ifdef ZERO_EXT_EN
  assign logic_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);
`else
  assign logic_imm = 1'b0;
`endif

  assign mem_state = (state == S_FETCH) || (state == S_MRD) || (state == S_MWR);
  assign timeout   = mem_state && !mem_ready && (wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Counter only runs while a memory state is stalled; any exit or completion clears it
  always_comb begin
    state_next    = state;
    wait_cnt_next = (mem_state && !mem_ready && !timeout) ? wait_cnt + CNT_W'(1) : '0;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
                else if (timeout) state_next = S_FETCH;
      S_DECODE: begin
        if (opcode == OP_RTYPE)                       state_next = S_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW)  state_next = S_MADDR;
        else if (opcode == OP_BEQ)                    state_next = S_BRANCH;
        else if (opcode == OP_J)                      state_next = S_JUMP;
        else if (opcode == OP_ADDI || logic_imm)      state_next = S_IEXEC;
        else                                          state_next = S_FETCH;
      end
      S_MADDR:  state_next = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:    if (mem_ready) state_next = S_MWB;
                else if (timeout) state_next = S_FETCH;
      S_MWR:    if (mem_ready || timeout) state_next = S_FETCH;
      S_EXEC:   state_next = S_RWB;
      S_IEXEC:  state_next = S_IWB;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    ext_zero      = 1'b0;
    illegal       = 1'b0;
    mem_err       = 1'b0;
    state_out     = 4'd0;
    if (!rst) begin
      state_out = state;
      mem_err   = timeout;
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          ext_zero  = logic_imm;
          illegal   = (state_next == S_FETCH);
        end
        S_MADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_IEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = logic_imm ? 2'b11 : 2'b00;
          ext_zero  = logic_imm;
        end
        S_IWB: begin
          reg_write = 1'b1;
          ext_zero  = logic_imm;
        end
        default: ;
      endcase
    end
  end

endmodule
